banked_mem_responder: RTL and testbench

- Responder end of the cache-to-main-memory interface; services the word read/write requests issued by the cache controller during line eviction and line fill.
- Four interleaved banks selected by `addr[2:1]`. Each bank stays busy for a fixed number of cycles after accepting a request.
- Read data returns a fixed 2 cycles after acceptance.
- Back-to-back requests to four consecutive words (offsets 0,2,4,6) stream without stalling.

---
 rtl/banked_mem_responder_pkg.sv | 26 ++
 rtl/banked_mem_responder_if.sv | 17 +
 rtl/banked_mem_responder_bank.sv | 59 +++++
 rtl/banked_mem_responder.sv | 93 +++++++++
 tb/tb_banked_mem_responder.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/banked_mem_responder_pkg.sv
// Shared definitions for the cache-to-main-memory interface so that the cache
// controller and the banked responder agree on word size, bank decode and timing.
package mem_pkg;
    localparam int MEM_WORD_W         = 16;
    localparam int NUM_BANKS          = 4;
    localparam int BANK_SEL_LO        = 1;
    localparam int BANK_SEL_HI        = 2;
    localparam int CNT_W              = 3;
    localparam int DEFAULT_DEPTH_LOG2 = 13;
    localparam int DEFAULT_BANK_BUSY  = 4;
    localparam int READ_LATENCY       = 2;

    // Byte offsets of the four words of a line, one per bank
    localparam logic [2:0] OFFSET_W0 = 3'b000;
    localparam logic [2:0] OFFSET_W1 = 3'b010;
    localparam logic [2:0] OFFSET_W2 = 3'b100;
    localparam logic [2:0] OFFSET_W3 = 3'b110;

    typedef logic [MEM_WORD_W-1:0] word_t;

    typedef struct packed {
        logic       req;
        logic       illegal;
        logic [1:0] bank;
    } req_dec_t;
endpackage

// File: rtl/banked_mem_responder_if.sv
// Request/response bundle between the cache controller (master) and the
// banked memory responder (slave).
interface banked_mem_responder_if;
    import mem_pkg::*;

    logic [15:0] addr;
    word_t       data_in;
    logic        wr;
    logic        rd;
    word_t       data_out;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    modport master (output addr, data_in, wr, rd, input data_out, stall, busy, err);
    modport slave  (input addr, data_in, wr, rd, output data_out, stall, busy, err);
endinterface

// File: rtl/banked_mem_responder_bank.sv
// One memory bank: storage array, busy counter and the first read pipeline
// stage. The array is deliberately left without reset.
module mem_bank
    import mem_pkg::*;
#(
    parameter int ROW_W     = 11,
    parameter int BANK_BUSY = DEFAULT_BANK_BUSY
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             we,
    input  logic [ROW_W-1:0] row,
    input  word_t            din,
    output word_t            dout,
    output logic             busy
);
    localparam int               DEPTH    = 1 << ROW_W;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(BANK_BUSY - 1);

    word_t            mem_q [DEPTH];
    word_t            dout_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Busy counter next state: reload on accept, otherwise count down to zero
    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            cnt_d = CNT_LOAD;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Busy counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Array write and stage-1 read capture share the accept edge
    always_ff @(posedge clk) begin
        if (en && we) begin
            mem_q[row] <= din;
        end
        if (en && !we) begin
            dout_q <= mem_q[row];
        end
    end

    assign dout = dout_q;
    assign busy = (cnt_q != {CNT_W{1'b0}});
endmodule

// File: rtl/banked_mem_responder.sv
// Four-bank interleaved memory responder: request decode, reject/stall logic
// and the second read pipeline stage that muxes the captured bank word out.
module banked_mem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_LOG2 = DEFAULT_DEPTH_LOG2,
    parameter int BANK_BUSY  = DEFAULT_BANK_BUSY
) (
    input  logic                   clk,
    input  logic                   rst,
    banked_mem_responder_if.slave  bus
);
    localparam int ROW_W = DEPTH_LOG2 - 2;

    req_dec_t         dec_s;
    logic [ROW_W-1:0] row_s;
    logic             accept_s;
    logic [3:0]       busy_s;
    word_t            bank_dout_s [NUM_BANKS];

    logic             v1_q;
    logic             v1_d;
    logic [1:0]       sel_q;
    logic [1:0]       sel_d;
    word_t            data_out_q;
    word_t            data_out_d;

    // Request decode; an odd address or simultaneous rd/wr is illegal
    always_comb begin
        dec_s         = '0;
        dec_s.bank    = bus.addr[BANK_SEL_HI:BANK_SEL_LO];
        dec_s.req     = bus.rd | bus.wr;
        dec_s.illegal = (bus.rd & bus.wr) | (dec_s.req & bus.addr[0]);
    end

    assign row_s    = bus.addr[DEPTH_LOG2:3];
    assign accept_s = dec_s.req & ~dec_s.illegal & ~busy_s[dec_s.bank];

    // Address bits above the array size alias onto lower addresses
    if (DEPTH_LOG2 < 15) begin : g_alias
        logic unused_hi_s;
        assign unused_hi_s = ^bus.addr[15:DEPTH_LOG2+1];
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .ROW_W     (ROW_W),
            .BANK_BUSY (BANK_BUSY)
        ) u_bank (
            .clk  (clk),
            .rst  (rst),
            .en   (accept_s && (dec_s.bank == 2'(b))),
            .we   (bus.wr),
            .row  (row_s),
            .din  (bus.data_in),
            .dout (bank_dout_s[b]),
            .busy (busy_s[b])
        );
    end

    // Read pipeline next state: remember which bank holds the captured word
    always_comb begin
        v1_d = accept_s & bus.rd;
        if (accept_s && bus.rd) begin
            sel_d = dec_s.bank;
        end else begin
            sel_d = sel_q;
        end
        if (v1_q) begin
            data_out_d = bank_dout_s[sel_q];
        end else begin
            data_out_d = '0;
        end
    end

    // Stage-2 output register; reset discards any in-flight read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v1_q       <= 1'b0;
            sel_q      <= 2'b00;
            data_out_q <= '0;
        end else begin
            v1_q       <= v1_d;
            sel_q      <= sel_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;
    assign bus.busy     = busy_s;
    assign bus.stall    = dec_s.req & ~dec_s.illegal & busy_s[dec_s.bank];
    assign bus.err      = dec_s.illegal;
endmodule

// File: tb/tb_banked_mem_responder.sv
// Directed bench for banked_mem_responder: a per-cycle vector table plus a
// hand-written asynchronous reset sequence.
module tb_banked_mem_responder;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    banked_mem_responder_if bus ();

    banked_mem_responder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] din;
        logic        e_err;
        logic        e_stall;
        logic [3:0]  e_busy;
        logic [15:0] e_dout;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din,
                     input logic e_err, input logic e_stall, input logic [3:0] e_busy, input logic [15:0] e_dout);
        vec_t t;
        t.rd = rd; t.wr = wr; t.addr = addr; t.din = din;
        t.e_err = e_err; t.e_stall = e_stall; t.e_busy = e_busy; t.e_dout = e_dout;
        vecs.push_back(t);
    endtask

    task automatic idle(input logic [3:0] e_busy, input logic [15:0] e_dout);
        v(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, e_busy, e_dout);
    endtask

    task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
        bus.rd = rd; bus.wr = wr; bus.addr = addr; bus.data_in = din;
    endtask

    task automatic cycle(input logic rd, input logic wr, input logic [15:0] addr, input logic [15:0] din);
        @(posedge clk);
        #1;
        drive(rd, wr, addr, din);
        @(negedge clk);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);

        // Write then read one word
        v(0,1,16'h0010,16'hBEEF, 0,0,4'b0000,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'h0000); idle(4'b0001,16'h0000);
        idle(4'b0000,16'h0000);
        v(1,0,16'h0010,16'h0000, 0,0,4'b0000,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'hBEEF); idle(4'b0001,16'h0000);
        idle(4'b0000,16'h0000);
        // Streaming fill and read of a four-word line
        v(0,1,16'h0020,16'h1111, 0,0,4'b0000,16'h0000);
        v(0,1,16'h0022,16'h2222, 0,0,4'b0001,16'h0000);
        v(0,1,16'h0024,16'h3333, 0,0,4'b0011,16'h0000);
        v(0,1,16'h0026,16'h4444, 0,0,4'b0111,16'h0000);
        idle(4'b1110,16'h0000); idle(4'b1100,16'h0000); idle(4'b1000,16'h0000);
        idle(4'b0000,16'h0000);
        v(1,0,16'h0020,16'h0000, 0,0,4'b0000,16'h0000);
        v(1,0,16'h0022,16'h0000, 0,0,4'b0001,16'h0000);
        v(1,0,16'h0024,16'h0000, 0,0,4'b0011,16'h1111);
        v(1,0,16'h0026,16'h0000, 0,0,4'b0111,16'h2222);
        idle(4'b1110,16'h3333); idle(4'b1100,16'h4444); idle(4'b1000,16'h0000);
        idle(4'b0000,16'h0000);
        // Same-bank conflict: stalled requests are dropped and re-presented
        v(0,1,16'h0030,16'h3030, 0,0,4'b0000,16'h0000);
        v(0,1,16'h0038,16'h3838, 0,1,4'b0001,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'h0000);
        v(0,1,16'h0038,16'h3838, 0,0,4'b0000,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'h0000); idle(4'b0001,16'h0000);
        idle(4'b0000,16'h0000);
        v(1,0,16'h0030,16'h0000, 0,0,4'b0000,16'h0000);
        v(1,0,16'h0038,16'h0000, 0,1,4'b0001,16'h0000);
        v(1,0,16'h0038,16'h0000, 0,1,4'b0001,16'h3030);
        v(1,0,16'h0038,16'h0000, 0,1,4'b0001,16'h0000);
        v(1,0,16'h0038,16'h0000, 0,0,4'b0000,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'h3838); idle(4'b0001,16'h0000);
        idle(4'b0000,16'h0000);
        // Illegal requests: no accept, no stall, no counter reload, no write
        v(0,1,16'h0040,16'h5A5A, 0,0,4'b0000,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'h0000); idle(4'b0001,16'h0000);
        idle(4'b0000,16'h0000);
        v(1,1,16'h0040,16'hFFFF, 1,0,4'b0000,16'h0000);
        idle(4'b0000,16'h0000);
        v(1,0,16'h0041,16'h0000, 1,0,4'b0000,16'h0000);
        idle(4'b0000,16'h0000);
        v(1,0,16'h0040,16'h0000, 0,0,4'b0000,16'h0000);
        v(1,1,16'h0040,16'hFFFF, 1,0,4'b0001,16'h0000);
        idle(4'b0001,16'h5A5A); idle(4'b0001,16'h0000); idle(4'b0000,16'h0000);
        v(1,0,16'h0040,16'h0000, 0,0,4'b0000,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'h5A5A); idle(4'b0001,16'h0000);
        idle(4'b0000,16'h0000);
        // Upper address bits alias
        v(0,1,16'h0000,16'hAAAA, 0,0,4'b0000,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'h0000); idle(4'b0001,16'h0000);
        idle(4'b0000,16'h0000);
        v(1,0,16'h8000,16'h0000, 0,0,4'b0000,16'h0000);
        idle(4'b0001,16'h0000); idle(4'b0001,16'hAAAA); idle(4'b0001,16'h0000);
        idle(4'b0000,16'h0000);

        #12;
        chk("reset_busy", -1, {12'h000, bus.busy}, 16'h0000);
        chk("reset_dout", -1, bus.data_out, 16'h0000);
        chk("reset_err", -1, {15'h0000, bus.err}, 16'h0000);
        chk("reset_stall", -1, {15'h0000, bus.stall}, 16'h0000);
        #1 rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].din);
            chk("err", i, {15'h0000, bus.err}, {15'h0000, vecs[i].e_err});
            chk("stall", i, {15'h0000, bus.stall}, {15'h0000, vecs[i].e_stall});
            chk("busy", i, {12'h000, bus.busy}, {12'h000, vecs[i].e_busy});
            chk("dout", i, bus.data_out, vecs[i].e_dout);
        end

        // Asynchronous reset while a read is in flight
        cycle(1'b0, 1'b1, 16'h0050, 16'h5050);
        chk("rst_wr_stall", 100, {15'h0000, bus.stall}, 16'h0000);
        repeat (4) cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
        cycle(1'b1, 1'b0, 16'h0050, 16'h0000);
        chk("rst_rd_stall", 101, {15'h0000, bus.stall}, 16'h0000);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("pre_rst_busy", 102, {12'h000, bus.busy}, 16'h0001);
        #2 rst = 1'b0;
        #1;
        chk("rst_busy", 103, {12'h000, bus.busy}, 16'h0000);
        chk("rst_dout", 104, bus.data_out, 16'h0000);
        @(posedge clk);
        #1;
        chk("rst_lost_dout", 105, bus.data_out, 16'h0000);
        #2;
        rst = 1'b1;
        drive(1'b1, 1'b0, 16'h0050, 16'h0000);
        @(negedge clk);
        chk("rel_stall", 106, {15'h0000, bus.stall}, 16'h0000);
        chk("rel_busy", 107, {12'h000, bus.busy}, 16'h0000);
        chk("rel_dout", 108, bus.data_out, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("rel_busy1", 109, {12'h000, bus.busy}, 16'h0001);
        chk("rel_dout1", 110, bus.data_out, 16'h0000);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("rel_dout2", 111, bus.data_out, 16'h5050);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("rel_dout3", 112, bus.data_out, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
